// File: rtl/fft8_pkg.sv
// Shared types and constants for the 8-point FFT sequencer and stage blocks.
// No logic here: state enum, frame constants and the 3-bit bit-reverse helper.
package fft8_pkg;

    localparam int FFT_N         = 8;
    localparam int FFT_LOG2N     = 3;
    localparam int FFT_STAGE_LAT = 3;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FIRE  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fft8_state_e;

    function automatic logic [FFT_LOG2N-1:0] bitrev3(input logic [FFT_LOG2N-1:0] n);
        return {n[0], n[1], n[2]};
    endfunction

endpackage

// File: rtl/fft8_bitrev_loader.sv
// Input frame buffer: sample n lands in slot bitrev3(n); one-cycle write, contents held until overwritten.
// No backpressure of its own; frame_full_o strobes on the write of the 8th sample.
module fft8_bitrev_loader
    import fft8_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_re_i,
    input  logic [WIDTH-1:0]         wr_im_i,
    output logic [FFT_N*WIDTH-1:0]   fft_in_re_o,
    output logic [FFT_N*WIDTH-1:0]   fft_in_im_o,
    output logic                     frame_full_o
);

    logic [FFT_LOG2N-1:0] in_cnt_q, in_cnt_d;
    logic [WIDTH-1:0]     buf_re_q [FFT_N];
    logic [WIDTH-1:0]     buf_im_q [FFT_N];

    // The 3-bit counter wraps to 0 on its own after sample 7.
    assign in_cnt_d     = wr_en_i ? in_cnt_q + 3'd1 : in_cnt_q;
    assign frame_full_o = wr_en_i && (in_cnt_q == 3'(FFT_N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_cnt_q <= '0;
            for (int k = 0; k < FFT_N; k++) begin
                buf_re_q[k] <= '0;
                buf_im_q[k] <= '0;
            end
        end else begin
            in_cnt_q <= in_cnt_d;
            if (wr_en_i) begin
                buf_re_q[bitrev3(in_cnt_q)] <= wr_re_i;
                buf_im_q[bitrev3(in_cnt_q)] <= wr_im_i;
            end
        end
    end

    always_comb begin
        fft_in_re_o = '0;
        fft_in_im_o = '0;
        for (int k = 0; k < FFT_N; k++) begin
            fft_in_re_o[k*WIDTH +: WIDTH] = buf_re_q[k];
            fft_in_im_o[k*WIDTH +: WIDTH] = buf_im_q[k];
        end
    end

endmodule

// File: rtl/fft8_seq_ctrl.sv
// Sequencer for the 3-stage 8-point FFT: load 8 samples bit-reversed, fire, wait STAGE_LAT, drain 8 bins.
// First bin 5 cycles after the 8th accept; output bins hold stable while m_ready is low.
module fft8_seq_ctrl
    import fft8_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int N         = FFT_N,
    parameter int STAGE_LAT = FFT_STAGE_LAT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH-1:0]       s_re,
    input  logic [WIDTH-1:0]       s_im,
    output logic [N*WIDTH-1:0]     fft_in_re,
    output logic [N*WIDTH-1:0]     fft_in_im,
    input  logic [N*WIDTH-1:0]     fft_out_re,
    input  logic [N*WIDTH-1:0]     fft_out_im,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_re,
    output logic [WIDTH-1:0]       m_im,
    output logic [2:0]             m_idx,
    output logic                   m_last,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int WCW = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;

    fft8_state_e          state_q, state_d;
    logic [WCW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [FFT_LOG2N-1:0] out_cnt_q, out_cnt_d;
    logic [WIDTH-1:0]     obuf_re_q [N];
    logic [WIDTH-1:0]     obuf_im_q [N];
    logic                 capture;
    logic                 frame_full;
    logic                 handshake;

    assign s_ready = rst_n && (state_q == LOAD);

    fft8_bitrev_loader #(
        .WIDTH        (WIDTH)
    ) u_loader (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (s_valid && s_ready),
        .wr_re_i      (s_re),
        .wr_im_i      (s_im),
        .fft_in_re_o  (fft_in_re),
        .fft_in_im_o  (fft_in_im),
        .frame_full_o (frame_full)
    );

    assign m_valid    = (state_q == DRAIN);
    assign handshake  = m_valid && m_ready;
    assign m_re       = obuf_re_q[out_cnt_q];
    assign m_im       = obuf_im_q[out_cnt_q];
    assign m_idx      = out_cnt_q;
    assign m_last     = (out_cnt_q == 3'(N - 1));
    assign busy       = (state_q != LOAD);
    // A reset arriving on the bin-7 handshake cycle must not report a completed frame.
    assign frame_done = rst_n && handshake && m_last;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        out_cnt_d  = out_cnt_q;
        capture    = 1'b0;
        case (state_q)
            LOAD: begin
                if (frame_full) state_d = FIRE;
            end
            FIRE: begin
                state_d    = WAIT;
                wait_cnt_d = '0;
            end
            WAIT: begin
                if (wait_cnt_q == WCW'(STAGE_LAT - 1)) begin
                    capture   = 1'b1;
                    state_d   = DRAIN;
                    out_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (handshake) begin
                    out_cnt_d = out_cnt_q + 3'd1;
                    if (m_last) state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            wait_cnt_q <= '0;
            out_cnt_q  <= '0;
            for (int k = 0; k < N; k++) begin
                obuf_re_q[k] <= '0;
                obuf_im_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            out_cnt_q  <= out_cnt_d;
            if (capture) begin
                for (int k = 0; k < N; k++) begin
                    obuf_re_q[k] <= fft_out_re[k*WIDTH +: WIDTH];
                    obuf_im_q[k] <= fft_out_im[k*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// Bench for fft8_seq_ctrl: a 3-cycle DFT stands in for the stage chain, and expected bins
// are the rounded DFT of the accepted samples in arrival order.
module tb_fft8_seq_ctrl;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           s_valid;
    logic           s_ready;
    logic [W-1:0]   s_re, s_im;
    logic [8*W-1:0] fft_in_re, fft_in_im;
    logic [8*W-1:0] fft_out_re, fft_out_im;
    logic           m_valid;
    logic           m_ready;
    logic [W-1:0]   m_re, m_im;
    logic [2:0]     m_idx;
    logic           m_last;
    logic           busy;
    logic           frame_done;

    int ntests = 0;
    int nfail  = 0;

    int xre [8];
    int xim [8];
    int exp_re [8];
    int exp_im [8];
    int slot_of [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    bit pat [4]     = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    fft8_seq_ctrl #(.WIDTH(W), .N(8), .STAGE_LAT(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_re       (s_re),
        .s_im       (s_im),
        .fft_in_re  (fft_in_re),
        .fft_in_im  (fft_in_im),
        .fft_out_re (fft_out_re),
        .fft_out_im (fft_out_im),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_re       (m_re),
        .m_im       (m_im),
        .m_idx      (m_idx),
        .m_last     (m_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    function automatic int rnd(input real r);
        return (r >= 0.0) ? int'($floor(r + 0.5)) : -int'($floor(-r + 0.5));
    endfunction

    function automatic int dft_bin(input int ar [8], input int ai [8], input int k, input bit want_im);
        real sr, si, th;
        sr = 0.0;
        si = 0.0;
        for (int n = 0; n < 8; n++) begin
            th = 2.0 * 3.14159265358979 * $itor((k * n) % 8) / 8.0;
            sr = sr + $itor(ar[n]) * $cos(th) + $itor(ai[n]) * $sin(th);
            si = si + $itor(ai[n]) * $cos(th) - $itor(ar[n]) * $sin(th);
        end
        return want_im ? rnd(si) : rnd(sr);
    endfunction

    // Stand-in stage chain: DFT of the bus (slot order undone) through 3 registers.
    logic [8*W-1:0] st_re [3];
    logic [8*W-1:0] st_im [3];
    int             sm_xr [8];
    int             sm_xi [8];
    logic [8*W-1:0] sm_nr, sm_ni;
    assign fft_out_re = st_re[2];
    assign fft_out_im = st_im[2];

    always @(posedge clk) begin
        for (int n = 0; n < 8; n++) begin
            sm_xr[n] = int'($signed(fft_in_re[slot_of[n]*W +: W]));
            sm_xi[n] = int'($signed(fft_in_im[slot_of[n]*W +: W]));
        end
        for (int k = 0; k < 8; k++) begin
            sm_nr[k*W +: W] = 16'(dft_bin(sm_xr, sm_xi, k, 1'b0));
            sm_ni[k*W +: W] = 16'(dft_bin(sm_xr, sm_xi, k, 1'b1));
        end
        st_re[0] <= sm_nr;
        st_im[0] <= sm_ni;
        st_re[1] <= st_re[0];
        st_im[1] <= st_im[0];
        st_re[2] <= st_re[1];
        st_im[2] <= st_im[1];
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] req);
        ntests++;
        assert (obs === req) else begin
            nfail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, req);
        end
    endtask

    // kind: 0 impulse(1000), 1 ramp s_re=n, 2 DC 100, 3 random
    task automatic prep(input int kind);
        for (int n = 0; n < 8; n++) begin
            case (kind)
                0:       begin xre[n] = (n == 0) ? 1000 : 0; xim[n] = 0; end
                1:       begin xre[n] = n;                   xim[n] = 0; end
                2:       begin xre[n] = 100;                 xim[n] = 0; end
                default: begin
                    xre[n] = int'($urandom_range(0, 4000)) - 2000;
                    xim[n] = int'($urandom_range(0, 4000)) - 2000;
                end
            endcase
        end
        for (int k = 0; k < 8; k++) begin
            exp_re[k] = dft_bin(xre, xim, k, 1'b0);
            exp_im[k] = dft_bin(xre, xim, k, 1'b1);
        end
    endtask

    task automatic load_frame(input int gap_pct, input bit hold);
        int n = 0;
        int guard = 0;
        while (n < 8 && guard < 400) begin
            s_valid = ($urandom_range(0, 99) >= gap_pct);
            s_re    = s_valid ? 16'(xre[n]) : 16'($urandom);
            s_im    = s_valid ? 16'(xim[n]) : 16'($urandom);
            @(negedge clk);
            chk("load_s_ready", s_ready, 1);
            chk("load_busy", busy, 0);
            if (s_valid && s_ready) n++;
            @(posedge clk); #1;
            guard++;
        end
        chk("load_timeout", n, 8);
        s_valid = hold;
        s_re    = 16'($urandom);
        s_im    = 16'($urandom);
    endtask

    // Starts in the FIRE cycle; mode 0 ready=1, 1 pattern 1,0,0,1, 2 random.
    task automatic drain_frame(input int mode, input int stop_after);
        int k = 0;
        int cyc = 0;
        int fd = 0;
        while (k < stop_after && cyc < 400) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = pat[cyc % 4];
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            chk("drain_s_ready", s_ready, 0);
            chk("drain_busy", busy, 1);
            if (cyc == 0) begin
                for (int n = 0; n < 8; n++) begin
                    chk("fire_slot_re", $signed(fft_in_re[slot_of[n]*W +: W]), xre[n]);
                    chk("fire_slot_im", $signed(fft_in_im[slot_of[n]*W +: W]), xim[n]);
                end
            end
            if (cyc < 4) chk("pre_m_valid", m_valid, 0);
            else if (cyc == 4) chk("first_m_valid", m_valid, 1);
            if (m_valid === 1'b1) begin
                chk("bin_re", $signed(m_re), exp_re[k]);
                chk("bin_im", $signed(m_im), exp_im[k]);
                chk("bin_idx", m_idx, k);
                chk("bin_last", m_last, (k == 7));
                chk("frame_done", frame_done, (m_ready && k == 7));
                if (m_ready) begin
                    k++;
                    fd += int'(frame_done);
                end
            end else begin
                chk("frame_done_idle", frame_done, 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("drain_timeout", k, stop_after);
        s_valid = 1'b0;
        if (stop_after == 8) begin
            chk("frame_done_count", fd, 1);
            @(negedge clk);
            chk("post_m_valid", m_valid, 0);
            chk("post_busy", busy, 0);
            chk("post_s_ready", s_ready, 1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_re    = '0;
        s_im    = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_s_ready_low", s_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_re", m_re, 0);
        chk("rst_m_im", m_im, 0);
        chk("rst_m_idx", m_idx, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_fft_in_zero", (fft_in_re == '0) && (fft_in_im == '0), 1);
        @(posedge clk); #1;

        prep(0); load_frame(0, 1'b0);  drain_frame(0, 8);
        prep(1); load_frame(0, 1'b0);  drain_frame(0, 8);
        prep(3); load_frame(0, 1'b0);  drain_frame(1, 8);
        prep(3); load_frame(40, 1'b1); drain_frame(2, 8);
        prep(3); load_frame(30, 1'b0); drain_frame(0, 8);
        prep(2); load_frame(0, 1'b1);  drain_frame(0, 8);
        prep(0); load_frame(0, 1'b0);  drain_frame(0, 8);

        prep(3); load_frame(0, 1'b0); drain_frame(0, 4);
        rst_n   = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        chk("midrst_frame_done", frame_done, 0);
        chk("midrst_s_ready", s_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_s_ready", s_ready, 1);
        chk("midrst_m_idx", m_idx, 0);
        chk("midrst_m_re", m_re, 0);
        chk("midrst_frame_done2", frame_done, 0);
        chk("midrst_fft_in_zero", (fft_in_re == '0) && (fft_in_im == '0), 1);
        @(posedge clk); #1;
        prep(3); load_frame(20, 1'b0); drain_frame(2, 8);

        for (int f = 0; f < 6; f++) begin
            prep(3);
            load_frame(int'($urandom_range(0, 50)), 1'($urandom_range(0, 1)));
            drain_frame(int'($urandom_range(0, 2)), 8);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
